// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback write-port block.
package wb_pkg;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_entry_t;

    // Little-endian lane select; unknown load kinds fall back to a full word.
    function automatic logic [31:0] load_extract(input logic [2:0]  lt,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (lt)
            LT_LB:   return {{24{b[7]}}, b};
            LT_LBU:  return {24'd0, b};
            LT_LH:   return {{16{h[15]}}, h};
            LT_LHU:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/wb_md_fifo.sv
// In-order FIFO buffering mult/div results until the write port is free.
module wb_md_fifo
    import wb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  wb_entry_t wdata_i,
    input  logic      pop_i,
    output wb_entry_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    wb_entry_t   mem_q [Depth];
    logic        do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/wb_write_port.sv
// Register-file write port: pipeline results win, mult/div results drain from a FIFO.
// Optional starvation guard built when WB_STARVE_GUARD_EN is defined.
module wb_write_port
    import wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_RegWrite,
    input  logic        mem_MemtoReg,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_read_data,
    input  logic [4:0]  mem_dest,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_dest,
    input  logic [31:0] md_result,
    output logic [31:0] write_data,
    output logic [4:0]  write_register,
    output logic        RegWrite,
    output logic        wb_stall
);

    if (FIFO_DEPTH < 2 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("wb_write_port: FIFO_DEPTH must be >= 2 and STARVE_LIMIT >= 1");
    end

    logic      pw, stall;
    logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
    wb_entry_t fifo_in, fifo_head;

    logic        we_q, we_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;

    assign pw        = mem_valid & mem_RegWrite & (mem_dest != ZERO_REG) & ~stall;
    assign md_ready  = ~rst & ~fifo_full;
    // Writes to r0 are accepted but never enqueued.
    assign fifo_push = md_valid & md_ready & (md_dest != ZERO_REG);
    assign fifo_pop  = ~pw & ~fifo_empty;
    assign fifo_in   = '{dest: md_dest, data: md_result};

    wb_md_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_md_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_in),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntTrip = CntW'(STARVE_LIMIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stall_q, stall_d;

    // The cycle the count would reach the limit raises the stall and restarts counting.
    always_comb begin
        cnt_d   = '0;
        stall_d = 1'b0;
        if (!fifo_empty && !fifo_pop) begin
            if (cnt_q == CntTrip) stall_d = 1'b1;
            else                  cnt_d   = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

    assign wb_stall = stall;

    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (pw) begin
            we_d    = 1'b1;
            wreg_d  = mem_dest;
            wdata_d = mem_MemtoReg ? load_extract(mem_load_type, mem_addr_lo, mem_read_data)
                                   : mem_alu_result;
        end else if (fifo_pop) begin
            we_d    = 1'b1;
            wreg_d  = fifo_head.dest;
            wdata_d = fifo_head.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign RegWrite       = we_q;
    assign write_register = wreg_q;
    assign write_data     = wdata_q;

endmodule

// File: tb/tb_wb_write_port.sv
// Self-checking bench for wb_write_port: vector table plus scoreboard of expected writes.
module tb_wb_write_port;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_RegWrite, mem_MemtoReg;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_result, mem_read_data;
    logic [4:0]  mem_dest;
    logic        md_valid, md_ready;
    logic [4:0]  md_dest;
    logic [31:0] md_result;
    logic [31:0] write_data;
    logic [4:0]  write_register;
    logic        RegWrite, wb_stall;

    wb_write_port dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_RegWrite   (mem_RegWrite),
        .mem_MemtoReg   (mem_MemtoReg),
        .mem_load_type  (mem_load_type),
        .mem_addr_lo    (mem_addr_lo),
        .mem_alu_result (mem_alu_result),
        .mem_read_data  (mem_read_data),
        .mem_dest       (mem_dest),
        .md_valid       (md_valid),
        .md_ready       (md_ready),
        .md_dest        (md_dest),
        .md_result      (md_result),
        .write_data     (write_data),
        .write_register (write_register),
        .RegWrite       (RegWrite),
        .wb_stall       (wb_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        valid;
        logic        regwr;
        logic        m2r;
        logic [2:0]  lt;
        logic [1:0]  lo;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  dest;
        logic        we_exp;
        logic [31:0] data_exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Every write the DUT makes must be the next entry of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && RegWrite === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got dest %0d data %h, want no write",
                         write_register, write_data);
            end else begin
                e = sb.pop_front();
                if (write_register !== e.dest || write_data !== e.data) begin
                    n_err++;
                    $display("FAIL sb_write: got dest %0d data %h, want dest %0d data %h",
                             write_register, write_data, e.dest, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid      = 1'b0;
        mem_RegWrite   = 1'b0;
        mem_MemtoReg   = 1'b0;
        mem_load_type  = LT_LW;
        mem_addr_lo    = 2'd0;
        mem_alu_result = '0;
        mem_read_data  = '0;
        mem_dest       = '0;
        md_valid       = 1'b0;
        md_dest        = '0;
        md_result      = '0;
    endtask

    task automatic pipe(input logic [4:0] d, input logic [31:0] alu);
        mem_valid      = 1'b1;
        mem_RegWrite   = 1'b1;
        mem_MemtoReg   = 1'b0;
        mem_dest       = d;
        mem_alu_result = alu;
    endtask

    task automatic md(input logic v, input logic [4:0] d, input logic [31:0] r);
        md_valid  = v;
        md_dest   = d;
        md_result = r;
    endtask

    task automatic expect_wr(input logic [4:0] d, input logic [31:0] data);
        sb.push_back('{dest: d, data: data});
    endtask

    function automatic vec_t mk(input logic v, input logic rw, input logic m2r,
                                input logic [2:0] lt, input logic [1:0] lo,
                                input logic [31:0] alu, input logic [31:0] rd,
                                input logic [4:0] dest, input logic we,
                                input logic [31:0] data);
        vec_t t;
        t = '{valid: v, regwr: rw, m2r: m2r, lt: lt, lo: lo, alu: alu, rd: rd,
              dest: dest, we_exp: we, data_exp: data};
        return t;
    endfunction

    localparam logic [31:0] RD = 32'h80FF_7F01;

    logic [4:0]  last_dest;
    logic [31:0] last_data;

    initial begin
        vecs.push_back(mk(1, 1, 1, LT_LB,  2'd3, '0, RD, 5'd8,  1, 32'hFFFF_FF80));
        vecs.push_back(mk(1, 1, 1, LT_LHU, 2'd2, '0, RD, 5'd9,  1, 32'h0000_80FF));
        vecs.push_back(mk(1, 1, 1, LT_LB,  2'd0, '0, RD, 5'd10, 1, 32'h0000_0001));
        vecs.push_back(mk(1, 1, 1, LT_LB,  2'd1, '0, RD, 5'd11, 1, 32'h0000_007F));
        vecs.push_back(mk(1, 1, 1, LT_LBU, 2'd3, '0, RD, 5'd12, 1, 32'h0000_0080));
        vecs.push_back(mk(1, 1, 1, LT_LBU, 2'd2, '0, RD, 5'd13, 1, 32'h0000_00FF));
        vecs.push_back(mk(1, 1, 1, LT_LH,  2'd0, '0, RD, 5'd14, 1, 32'h0000_7F01));
        vecs.push_back(mk(1, 1, 1, LT_LH,  2'd2, '0, RD, 5'd15, 1, 32'hFFFF_80FF));
        vecs.push_back(mk(1, 1, 1, LT_LH,  2'd3, '0, RD, 5'd16, 1, 32'hFFFF_80FF));
        vecs.push_back(mk(1, 1, 1, LT_LHU, 2'd0, '0, RD, 5'd17, 1, 32'h0000_7F01));
        vecs.push_back(mk(1, 1, 1, LT_LW,  2'd1, '0, RD, 5'd18, 1, RD));
        vecs.push_back(mk(1, 1, 1, 3'd7,   2'd1, '0, RD, 5'd19, 1, RD));
        vecs.push_back(mk(1, 1, 0, LT_LB,  2'd3, 32'h1234_5678, RD, 5'd31, 1, 32'h1234_5678));
        vecs.push_back(mk(0, 1, 0, LT_LW,  2'd0, 32'hDEAD_0001, RD, 5'd7,  0, '0));
        vecs.push_back(mk(1, 0, 0, LT_LW,  2'd0, 32'hDEAD_0002, RD, 5'd6,  0, '0));
        vecs.push_back(mk(1, 1, 0, LT_LW,  2'd0, 32'hDEAD_0003, RD, 5'd0,  0, '0));
        vecs.push_back(mk(1, 1, 1, LT_LBU, 2'd0, '0, 32'h0000_00AB, 5'd1, 1, 32'h0000_00AB));

        rst = 1'b1;
        idle_inputs();
        step();
        step();
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_wreg",     32'(write_register), 32'd0);
        check("rst_wdata",    write_data, 32'd0);
        check("rst_stall",    32'(wb_stall), 32'd0);
        check("rst_md_ready", 32'(md_ready), 32'd0);
        #2 rst = 1'b0;
        #1 check("post_rst_md_ready", 32'(md_ready), 32'd1);
        step();

        // Load extraction and write-enable qualification.
        last_dest = '0;
        last_data = '0;
        foreach (vecs[i]) begin
            mem_valid      = vecs[i].valid;
            mem_RegWrite   = vecs[i].regwr;
            mem_MemtoReg   = vecs[i].m2r;
            mem_load_type  = vecs[i].lt;
            mem_addr_lo    = vecs[i].lo;
            mem_alu_result = vecs[i].alu;
            mem_read_data  = vecs[i].rd;
            mem_dest       = vecs[i].dest;
            if (vecs[i].we_exp) expect_wr(vecs[i].dest, vecs[i].data_exp);
            step();
            check("vec_we", 32'(RegWrite), 32'(vecs[i].we_exp));
            if (vecs[i].we_exp) begin
                last_dest = vecs[i].dest;
                last_data = vecs[i].data_exp;
            end else begin
                check("vec_hold_wreg",  32'(write_register), 32'(last_dest));
                check("vec_hold_wdata", write_data, last_data);
            end
        end
        idle_inputs();
        step();

        // Pipeline write to r0 lets the FIFO drain in the same cycle.
        pipe(5'd3, 32'h0000_00D0);
        md(1'b1, 5'd5, 32'h0000_1234);
        expect_wr(5'd3, 32'h0000_00D0);
        check("zr_md_ready", 32'(md_ready), 32'd1);
        step();
        md(1'b0, '0, '0);
        pipe(5'd0, 32'h0000_00D1);
        expect_wr(5'd5, 32'h0000_1234);
        step();
        check("zr_wreg",  32'(write_register), 32'd5);
        check("zr_wdata", write_data, 32'h0000_1234);
        idle_inputs();
        step();
        check("zr_idle", 32'(RegWrite), 32'd0);

        // Conflict: pipeline owns the port until it goes quiet, then FIFO drains in order.
        pipe(5'd3, 32'h0000_00A0);
        md(1'b1, 5'd10, 32'h0000_0111);
        expect_wr(5'd3, 32'h0000_00A0);
        step();
        pipe(5'd3, 32'h0000_00A1);
        md(1'b1, 5'd11, 32'h0000_0222);
        check("cf_ready_1", 32'(md_ready), 32'd1);
        expect_wr(5'd3, 32'h0000_00A1);
        step();
        pipe(5'd3, 32'h0000_00A2);
        md(1'b1, 5'd12, 32'h0000_0333);
        check("cf_full", 32'(md_ready), 32'd0);
        expect_wr(5'd3, 32'h0000_00A2);
        step();
        idle_inputs();
        expect_wr(5'd10, 32'h0000_0111);
        step();
        check("cf_first", 32'(write_register), 32'd10);
        expect_wr(5'd11, 32'h0000_0222);
        step();
        check("cf_second", 32'(write_register), 32'd11);
        step();
        check("cf_done", 32'(RegWrite), 32'd0);

`ifdef WB_STARVE_GUARD_EN
        // Starved FIFO forces a one-cycle stall; the held pipeline write follows.
        pipe(5'd3, 32'h0000_00B0);
        md(1'b1, 5'd20, 32'h0000_DEAD);
        expect_wr(5'd3, 32'h0000_00B0);
        step();
        md(1'b0, '0, '0);
        for (int k = 1; k <= 4; k++) begin
            check("sv_no_stall", 32'(wb_stall), 32'd0);
            pipe(5'd3, 32'h0000_00B0 + 32'(k));
            expect_wr(5'd3, 32'h0000_00B0 + 32'(k));
            step();
        end
        check("sv_stall", 32'(wb_stall), 32'd1);
        pipe(5'd3, 32'h0000_00B5);
        expect_wr(5'd20, 32'h0000_DEAD);
        step();
        check("sv_head", 32'(write_register), 32'd20);
        check("sv_stall_drop", 32'(wb_stall), 32'd0);
        expect_wr(5'd3, 32'h0000_00B5);
        step();
        check("sv_held_wreg",  32'(write_register), 32'd3);
        check("sv_held_wdata", write_data, 32'h0000_00B5);
        idle_inputs();
        step();
        check("sv_idle", 32'(RegWrite), 32'd0);
`else
        // Without the guard a full FIFO waits out any run of pipeline writes.
        pipe(5'd3, 32'h0000_00E0);
        md(1'b1, 5'd20, 32'h0000_DEAD);
        expect_wr(5'd3, 32'h0000_00E0);
        step();
        pipe(5'd3, 32'h0000_00E1);
        md(1'b1, 5'd21, 32'h0000_BEEF);
        check("ng_ready", 32'(md_ready), 32'd1);
        expect_wr(5'd3, 32'h0000_00E1);
        step();
        for (int k = 2; k <= 7; k++) begin
            pipe(5'd3, 32'h0000_00E0 + 32'(k));
            md(1'b1, 5'd22, 32'h0000_CAFE);
            check("ng_full",  32'(md_ready), 32'd0);
            check("ng_stall", 32'(wb_stall), 32'd0);
            expect_wr(5'd3, 32'h0000_00E0 + 32'(k));
            step();
        end
        idle_inputs();
        expect_wr(5'd20, 32'h0000_DEAD);
        step();
        check("ng_first", 32'(write_register), 32'd20);
        expect_wr(5'd21, 32'h0000_BEEF);
        step();
        check("ng_second", 32'(write_register), 32'd21);
        step();
        check("ng_idle", 32'(RegWrite), 32'd0);
`endif

        // Asynchronous reset with two entries queued and a write in flight.
        pipe(5'd3, 32'h0000_00C0);
        md(1'b1, 5'd14, 32'h0000_AAAA);
        expect_wr(5'd3, 32'h0000_00C0);
        step();
        pipe(5'd3, 32'h0000_00C1);
        md(1'b1, 5'd15, 32'h0000_BBBB);
        expect_wr(5'd3, 32'h0000_00C1);
        step();
        pipe(5'd3, 32'h0000_00C2);
        md(1'b0, '0, '0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_regwrite", 32'(RegWrite), 32'd0);
        check("ar_wreg",     32'(write_register), 32'd0);
        check("ar_wdata",    write_data, 32'd0);
        check("ar_md_ready", 32'(md_ready), 32'd0);
        check("ar_stall",    32'(wb_stall), 32'd0);
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("ar_release_ready", 32'(md_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("ar_no_stale", 32'(RegWrite), 32'd0);
        end

        step();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
